// File: rtl/mem_access_unit.sv
// MEM-stage data-memory sequencer: one req/ack transaction per access, store lane alignment,
// load lane extraction, misalign and timeout exceptions. Optional macro SIGNED_LOAD_EN adds sign_ext.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [10:0] ctrl_in,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef SIGNED_LOAD_EN
  input  logic        sign_ext,
`endif
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        exc_misalign,
  output logic        exc_bus,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        exc_mis_q, exc_mis_d;
  logic        exc_bus_q, exc_bus_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        sext_q, sext_d;

  logic mem_op, is_wr, aligned, accept, sext_in;
  logic unused_ctrl;

`ifdef SIGNED_LOAD_EN
  assign sext_in = sign_ext;
`else
  assign sext_in = 1'b0;
`endif

  assign unused_ctrl = ^{ctrl_in[10:9], ctrl_in[6:0]};

  function automatic logic [3:0] be_gen(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b01:   be_gen = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be_gen = 4'b0001 << off;
      default: be_gen = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_gen(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b01:   lane_gen = {2{wd[15:0]}};
      2'b10:   lane_gen = {4{wd[7:0]}};
      default: lane_gen = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic [1:0] off,
                                           input logic sx, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (sz)
      2'b01:   load_ext = {{16{sx & h[15]}}, h};
      2'b10:   load_ext = {{24{sx & b[7]}}, b};
      default: load_ext = rdata;
    endcase
  endfunction

  assign mem_op = valid_in & (ctrl_in[8] | ctrl_in[7]);
  assign is_wr  = ctrl_in[7];

  always_comb begin
    case (size)
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = 1'b1;
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  assign accept = (state_q == S_IDLE) & mem_op & aligned;
  assign stall  = accept | (state_q == S_BUSY);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    size_d      = size_q;
    off_d       = off_q;
    sext_d      = sext_q;
    rd_valid_d  = 1'b0;
    exc_mis_d   = 1'b0;
    exc_bus_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op && !aligned) begin
          exc_mis_d = 1'b1;
        end else if (accept) begin
          state_d     = S_BUSY;
          cnt_d       = 8'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = is_wr;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_be_d    = be_gen(size, addr[1:0]);
          mem_wdata_d = lane_gen(size, wdata);
          size_d      = size;
          off_d       = addr[1:0];
          sext_d      = sext_in;
        end
      end
      default: begin
        // An ack in the expiry cycle still completes the access normally.
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = load_ext(size_q, off_q, sext_q, mem_rdata);
          end
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          exc_bus_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      rd_data_q   <= 32'd0;
      rd_valid_q  <= 1'b0;
      exc_mis_q   <= 1'b0;
      exc_bus_q   <= 1'b0;
      size_q      <= 2'd0;
      off_q       <= 2'd0;
      sext_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      exc_mis_q   <= exc_mis_d;
      exc_bus_q   <= exc_bus_d;
      size_q      <= size_d;
      off_q       <= off_d;
      sext_q      <= sext_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign exc_misalign = exc_mis_q;
  assign exc_bus      = exc_bus_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written multi-cycle sequences,
// and randomized accesses checked against a byte-lane reference model.
module tb_mem_access_unit;

  localparam int TO = 4;
`ifdef SIGNED_LOAD_EN
  localparam bit SLE = 1'b1;
`else
  localparam bit SLE = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [10:0] ctrl_in;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        sign_ext;
  logic        stall;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        exc_misalign;
  logic        exc_bus;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int failures = 0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ctrl_in(ctrl_in), .size(size),
    .addr(addr), .wdata(wdata),
`ifdef SIGNED_LOAD_EN
    .sign_ext(sign_ext),
`endif
    .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid), .exc_misalign(exc_misalign),
    .exc_bus(exc_bus), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    bit          rd;
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdat;
    int          ack_at;   // BUSY cycle (1-based) carrying the ack; 0 = never
    bit          sx;
    bit          mis;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
    bit          bus;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: access described as a run of nb bytes starting at the byte offset.
  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 4;
    endcase
  endfunction

  function automatic bit m_aligned(input logic [1:0] sz, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(sz)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int nb = nbytes(sz);
    return 4'(((1 << nb) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int nb = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input logic [31:0] rdat, input bit sx);
    int nb = nbytes(sz);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
    v = (rdat >> (8*int'(a[1:0]))) & mask;
    if (SLE && sx && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic set_op(input bit rd, input bit wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input bit sx);
    valid_in   = 1'b1;
    ctrl_in    = 11'($urandom);
    ctrl_in[8] = rd;
    ctrl_in[7] = wr;
    size       = sz;
    addr       = a;
    wdata      = wd;
    sign_ext   = sx;
  endtask

  task automatic clear_op();
    valid_in = 1'b0;
    ctrl_in  = 11'($urandom);
    size     = 2'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
    sign_ext = ~sign_ext;
  endtask

  task automatic run_txn(input string nm, input vec_t v);
    bit acked;
    int c;
    set_op(v.rd, v.wr, v.sz, v.a, v.wd, v.sx);
    #1;
    chk({nm, " stall_accept"}, 32'(stall), 32'(!v.mis));
    @(posedge clk); #1;
    clear_op();
    #1;
    if (v.mis) begin
      chk({nm, " exc_misalign"}, 32'(exc_misalign), 32'd1);
      chk({nm, " mem_req_mis"}, 32'(mem_req), 32'd0);
      chk({nm, " stall_mis"}, 32'(stall), 32'd0);
      @(posedge clk); #1;
      chk({nm, " exc_misalign_pulse"}, 32'(exc_misalign), 32'd0);
      chk({nm, " mem_req_after_mis"}, 32'(mem_req), 32'd0);
    end else begin
      chk({nm, " mem_addr"}, mem_addr, v.a & 32'hFFFF_FFFC);
      chk({nm, " mem_be"}, 32'(mem_be), 32'(v.be));
      chk({nm, " mem_we"}, 32'(mem_we), 32'(v.wr));
      if (v.wr) chk({nm, " mem_wdata"}, mem_wdata, v.ewd);
      acked = 1'b0;
      c = 1;
      while (c <= TO && !acked) begin
        chk({nm, " mem_req_busy"}, 32'(mem_req), 32'd1);
        chk({nm, " stall_busy"}, 32'(stall), 32'd1);
        mem_ack   = (c == v.ack_at);
        mem_rdata = (c == v.ack_at) ? v.rdat : $urandom;
        @(posedge clk); #1;
        if (c == v.ack_at) acked = 1'b1;
        mem_ack = 1'b0;
        c++;
        #1;
      end
      chk({nm, " rd_valid"}, 32'(rd_valid), 32'(!v.bus && !v.wr));
      chk({nm, " exc_bus"}, 32'(exc_bus), 32'(v.bus));
      chk({nm, " mem_req_done"}, 32'(mem_req), 32'd0);
      chk({nm, " stall_done"}, 32'(stall), 32'd0);
      if (acked && !v.wr) chk({nm, " rd_data"}, rd_data, v.erd);
      @(posedge clk); #1;
      chk({nm, " rd_valid_pulse"}, 32'(rd_valid), 32'd0);
      chk({nm, " exc_bus_pulse"}, 32'(exc_bus), 32'd0);
    end
  endtask

  vec_t tbl[15];
  vec_t rv;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b0, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'b10, 32'h203, 32'hA5, 32'h0, 1, 1'b0, 1'b0, 4'h8, 32'hA5A5A5A5, 32'h0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'b01, 32'h302, 32'h0, 32'h80011234, 2, 1'b0, 1'b0, 4'hC, 32'h0, 32'h00008001, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'b01, 32'h302, 32'h0, 32'h80011234, 2, 1'b1, 1'b0, 4'hC, 32'h0,
                SLE ? 32'hFFFF8001 : 32'h00008001, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 2'b00, 32'h102, 32'h0, 32'h0, 0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'b00, 32'h400, 32'h0, 32'h0, 0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 2'b00, 32'h404, 32'h0, 32'h13579BDF, 4, 1'b0, 1'b0, 4'hF, 32'h0, 32'h13579BDF, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 2'b01, 32'h301, 32'h0, 32'h0, 0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 2'b10, 32'h101, 32'h0, 32'h11223344, 1, 1'b1, 1'b0, 4'h2, 32'h0, 32'h00000033, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 2'b01, 32'h206, 32'h1234ABCD, 32'h0, 2, 1'b0, 1'b0, 4'hC, 32'hABCDABCD, 32'h0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 2'b00, 32'h500, 32'hCAFEF00D, 32'h0, 1, 1'b0, 1'b0, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 2'b11, 32'h601, 32'h0, 32'h0, 0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 2'b10, 32'h103, 32'h0, 32'h80FFFFFF, 1, 1'b1, 1'b0, 4'h8, 32'h0,
                SLE ? 32'hFFFFFF80 : 32'h00000080, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 2'b01, 32'h702, 32'h0000BEEF, 32'h0, 0, 1'b0, 1'b0, 4'hC, 32'hBEEFBEEF, 32'h0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 2'b11, 32'h800, 32'h11223344, 32'h0, 2, 1'b0, 1'b0, 4'hF, 32'h11223344, 32'h0, 1'b0};

    rst_n = 1'b0; valid_in = 1'b0; ctrl_in = '0; size = '0; addr = '0; wdata = '0;
    sign_ext = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_be", 32'(mem_be), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset exc_misalign", 32'(exc_misalign), 32'd0);
    chk("reset exc_bus", 32'(exc_bus), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    rst_n = 1'b1;

    // Non-memory op and invalid memory op are ignored.
    valid_in = 1'b1; ctrl_in = 11'h67F; addr = 32'h102; size = 2'b00;
    #1;
    chk("nonmem stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("nonmem mem_req", 32'(mem_req), 32'd0);
    chk("nonmem exc_misalign", 32'(exc_misalign), 32'd0);
    valid_in = 1'b0; ctrl_in = 11'h180; addr = 32'h100;
    #1;
    chk("invalid stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("invalid mem_req", 32'(mem_req), 32'd0);

    // Ack while idle is ignored.
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("idle_ack rd_valid", 32'(rd_valid), 32'd0);
    chk("idle_ack mem_req", 32'(mem_req), 32'd0);

    for (int i = 0; i < 15; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Back-to-back: new op presented in the rd_valid cycle is accepted immediately.
    set_op(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
    @(posedge clk); #1;
    clear_op();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("b2b rd_valid", 32'(rd_valid), 32'd1);
    chk("b2b rd_data", rd_data, 32'h55);
    set_op(1'b0, 1'b1, 2'b10, 32'h21, 32'h7E, 1'b0);
    #1;
    chk("b2b stall_accept", 32'(stall), 32'd1);
    @(posedge clk); #1;
    clear_op();
    chk("b2b mem_req", 32'(mem_req), 32'd1);
    chk("b2b mem_addr", mem_addr, 32'h20);
    chk("b2b mem_be", 32'(mem_be), 32'h2);
    chk("b2b mem_wdata", mem_wdata, 32'h7E7E7E7E);
    chk("b2b mem_we", 32'(mem_we), 32'd1);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("b2b write rd_valid", 32'(rd_valid), 32'd0);
    chk("b2b write mem_req", 32'(mem_req), 32'd0);

    // Reset during a pending read abandons it; a late ack is ignored.
    set_op(1'b1, 1'b0, 2'b00, 32'h80, 32'h0, 1'b0);
    @(posedge clk); #1;
    clear_op();
    chk("rstbusy mem_req_before", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rstbusy mem_req", 32'(mem_req), 32'd0);
    chk("rstbusy rd_valid", 32'(rd_valid), 32'd0);
    chk("rstbusy exc_bus", 32'(exc_bus), 32'd0);
    chk("rstbusy stall", 32'(stall), 32'd0);
    chk("rstbusy mem_addr", mem_addr, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hFEEDFACE;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rstbusy late_ack rd_valid", 32'(rd_valid), 32'd0);
    for (int i = 0; i < TO + 1; i++) begin
      @(posedge clk); #1;
      chk("rstbusy no exc_bus", 32'(exc_bus), 32'd0);
      chk("rstbusy no mem_req", 32'(mem_req), 32'd0);
    end

    // Randomized accesses against the reference model.
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(1, 3);
      rv.rd = r[0];
      rv.wr = r[1];
      rv.sz = 2'($urandom);
      rv.a = $urandom;
      if ($urandom_range(0, 3) != 0) rv.a[1:0] = (rv.sz == 2'b01) ? {rv.a[1], 1'b0}
                                                : (rv.sz == 2'b10) ? rv.a[1:0] : 2'b00;
      rv.wd = $urandom;
      rv.rdat = $urandom;
      rv.ack_at = $urandom_range(0, TO);
      rv.sx = 1'($urandom);
      rv.mis = !m_aligned(rv.sz, rv.a);
      rv.be = m_be(rv.sz, rv.a);
      rv.ewd = m_wd(rv.sz, rv.wd);
      rv.erd = m_load(rv.sz, rv.a, rv.rdat, rv.sx);
      rv.bus = !rv.mis && (rv.ack_at == 0);
      run_txn($sformatf("rnd%0d", i), rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
